// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH_RUN   = 2'd0,
    FETCH_FLUSH = 2'd1,
    FETCH_FAULT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order instruction buffer of {pc, word} entries with push/pop/clear.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  fetch_entry_t           wdata,
  output fetch_entry_t           rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // NOTE: storage has no reset; count gates validity, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited imem requests, redirect flush.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        fetch_fault
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e  state, state_next;
  logic [31:0]   fetch_pc, fetch_pc_next;
  logic [CW-1:0] outstanding, outstanding_next;
  logic [CW-1:0] drop_cnt, drop_cnt_next;
  logic [OW-1:0] occupancy;
  logic [31:0]   in_use;
  logic [31:0]   target;
  logic          push, pop, clear, accept, trap;
  fetch_entry_t  push_entry, head;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign trap        = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign fetch_fault = (state == FETCH_FAULT);
`else
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^redirect_pc[1:0];
  assign trap           = 1'b0;
  assign fetch_fault    = 1'b0;
`endif

  assign target        = {redirect_pc[31:2], 2'b00};
  assign imem_req_addr = fetch_pc;
  assign inst_valid    = (occupancy != '0) && (state != FETCH_FAULT);
  assign inst          = inst_valid ? head.word : '0;
  assign inst_pc       = inst_valid ? head.pc   : '0;

  // With no drops pending, every outstanding request belongs to the current
  // sequential stream, so the oldest one sits 4*outstanding behind fetch_pc.
  assign push_entry.pc   = fetch_pc - 32'({outstanding, 2'b00});
  assign push_entry.word = imem_resp_data;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    pop              = 1'b0;
    clear            = 1'b0;
    push             = 1'b0;
    in_use           = '0;
    imem_req_valid   = 1'b0;
    accept           = 1'b0;
    outstanding_next = outstanding;
    drop_cnt_next    = drop_cnt;
    fetch_pc_next    = fetch_pc;
    state_next       = state;

    pop   = inst_valid && inst_ready && !redirect_valid;
    clear = redirect_valid && (state != FETCH_FAULT);
    // Credit counts the slot freed by this cycle's pop to sustain one fetch per cycle.
    in_use = 32'(occupancy) - 32'(pop) + 32'(outstanding);
    imem_req_valid = !rst && (state != FETCH_FAULT) && !redirect_valid &&
                     (in_use < 32'(FIFO_DEPTH));
    accept = imem_req_valid && imem_req_ready;
    push   = imem_resp_valid && (drop_cnt == '0) && !clear && (state != FETCH_FAULT);

    outstanding_next = outstanding + CW'(accept) - CW'(imem_resp_valid);

    if (clear)                                    drop_cnt_next = outstanding_next;
    else if (imem_resp_valid && drop_cnt != '0)   drop_cnt_next = drop_cnt - CW'(1);

    if (clear && !trap) fetch_pc_next = target;
    else if (accept)    fetch_pc_next = fetch_pc + PC_STEP;

    unique case (state)
      FETCH_RUN, FETCH_FLUSH: begin
        if (trap)                     state_next = FETCH_FAULT;
        else if (clear)               state_next = (outstanding_next != '0) ? FETCH_FLUSH : FETCH_RUN;
        else if (drop_cnt_next == '0) state_next = FETCH_RUN;
      end
      FETCH_FAULT: state_next = FETCH_FAULT;
      default:     state_next = FETCH_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH_RUN;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      fetch_pc    <= fetch_pc_next;
      outstanding <= outstanding_next;
      drop_cnt    <= drop_cnt_next;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (clear),
    .wdata (push_entry),
    .rdata (head),
    .count (occupancy)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory model, instruction scoreboard, directed scenarios.
module tb_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  typedef struct packed {
    logic [31:0] addr;
    int          due;
  } pend_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;
  logic        fetch_fault;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          mem_lat = 1;
  int          req_budget = 0;
  int          req_cnt = 0;
  int          base;
  exp_t        exp_q[$];
  pend_t       pend[$];
  logic [31:0] req_log[$];
  logic [31:0] want [3];

  fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .fetch_fault     (fetch_fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_inst(input logic [31:0] pc);
    exp_q.push_back('{pc: pc, word: mem_word(pc)});
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) next_cycle();
    check("drain_left", 32'(exp_q.size()), 32'd0);
    repeat (4) next_cycle();
  endtask

  // Memory: in-order responses, mem_lat cycles after acceptance; ready follows req_budget.
  initial begin
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    forever begin
      pend_t p;
      @(posedge clk);
      #2;
      imem_req_ready = (req_budget > 0);
      if (rst) begin
        pend.delete();
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
      end else if (pend.size() > 0 && pend[0].due <= cyc) begin
        p = pend.pop_front();
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(p.addr);
      end else begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && imem_req_valid && imem_req_ready) begin
      pend.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
      req_log.push_back(imem_req_addr);
      req_cnt++;
      req_budget--;
    end
  end

  // Scoreboard monitor: every consumed instruction must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && inst_valid && inst_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_inst: got pc %h word %h, expected none", inst_pc, inst);
      end else begin
        e = exp_q.pop_front();
        check("inst_pc", inst_pc, e.pc);
        check("inst_word", inst, e.word);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    mid();
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr", imem_req_addr, 32'h0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_fault", 32'(fetch_fault), 32'd0);

    // Streaming from RESET_PC: requests 0,4,8 back to back, first inst at cycle 2
    next_cycle();
    rst = 1'b0;
    req_budget = 3;
    expect_inst(32'h0); expect_inst(32'h4); expect_inst(32'h8);
    mid();
    check("c0_req_valid", 32'(imem_req_valid), 32'd1);
    check("c0_req_addr", imem_req_addr, 32'h0);
    check("c0_inst_valid", 32'(inst_valid), 32'd0);
    next_cycle(); mid();
    check("c1_req_addr", imem_req_addr, 32'h4);
    check("c1_inst_valid", 32'(inst_valid), 32'd0);
    next_cycle(); mid();
    check("c2_req_addr", imem_req_addr, 32'h8);
    check("c2_inst_valid", 32'(inst_valid), 32'd1);
    check("c2_inst_pc", inst_pc, 32'h0);
    next_cycle(); mid();
    check("c3_inst_pc", inst_pc, 32'h4);
    drain();

    // Decode stall: credit caps accepted requests at FIFO_DEPTH
    inst_ready = 1'b0;
    expect_inst(32'hC); expect_inst(32'h10);
    base = req_cnt;
    req_budget = 5;
    repeat (6) next_cycle();
    req_budget = 0;
    mid();
    check("stall_reqs", 32'(req_cnt - base), 32'd2);
    check("stall_inst_valid", 32'(inst_valid), 32'd1);
    check("stall_inst_pc", inst_pc, 32'hC);
    next_cycle();
    inst_ready = 1'b1;
    drain();

    // Redirect with two requests in flight: both responses dropped
    mem_lat = 4;
    expect_inst(32'h100);
    req_budget = 3;
    next_cycle();
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    mid();
    check("redir_req_valid", 32'(imem_req_valid), 32'd0);
    next_cycle();
    redirect_valid = 1'b0;
    mid();
    check("redir_req_addr", imem_req_addr, 32'h100);
    drain();
    mem_lat = 1;

    // Redirect coinciding with a response and a pop
    req_budget = 2;
    next_cycle();
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    mid();
    check("squash_inst_valid", 32'(inst_valid), 32'd1);
    check("squash_inst_pc", inst_pc, 32'h104);
    check("squash_resp_seen", 32'(imem_resp_valid), 32'd1);
    next_cycle();
    redirect_valid = 1'b0;
    expect_inst(32'h200);
    req_budget = 1;
    mid();
    check("post_squash_req_valid", 32'(imem_req_valid), 32'd1);
    check("post_squash_req_addr", imem_req_addr, 32'h200);
    check("post_squash_inst_valid", 32'(inst_valid), 32'd0);
    drain();

    // PC wrap past 0xFFFF_FFFC
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    next_cycle();
    redirect_valid = 1'b0;
    req_log.delete();
    expect_inst(32'hFFFF_FFF8); expect_inst(32'hFFFF_FFFC); expect_inst(32'h0);
    req_budget = 3;
    drain();
    want[0] = 32'hFFFF_FFF8;
    want[1] = 32'hFFFF_FFFC;
    want[2] = 32'h0000_0000;
    check("wrap_req_count", 32'(req_log.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      check("wrap_req_addr", (i < req_log.size()) ? req_log[i] : 32'hDEAD_BEEF, want[i]);

    // Misaligned redirect
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    next_cycle();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    base = req_cnt;
    req_budget = 2;
    mid();
    check("trap_fault", 32'(fetch_fault), 32'd1);
    check("trap_req_valid", 32'(imem_req_valid), 32'd0);
    check("trap_inst_valid", 32'(inst_valid), 32'd0);
    repeat (4) next_cycle();
    mid();
    check("trap_fault_held", 32'(fetch_fault), 32'd1);
    check("trap_req_valid_held", 32'(imem_req_valid), 32'd0);
    check("trap_no_reqs", 32'(req_cnt - base), 32'd0);
    next_cycle();
    req_budget = 0;
`else
    expect_inst(32'h100);
    req_budget = 1;
    mid();
    check("misalign_fault", 32'(fetch_fault), 32'd0);
    check("misalign_req_valid", 32'(imem_req_valid), 32'd1);
    check("misalign_req_addr", imem_req_addr, 32'h100);
    drain();
`endif

    // Reset asserted mid-operation clears everything
    rst = 1'b1;
    mid();
    check("rerst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rerst_req_addr", imem_req_addr, 32'h0);
    check("rerst_inst_valid", 32'(inst_valid), 32'd0);
    check("rerst_fault", 32'(fetch_fault), 32'd0);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the RISC-V core: owns the program counter, issues word requests to instruction memory over a valid/ready handshake, buffers returned words in a small in-order FIFO, and presents `inst` with its `inst_pc` to decode (immediate generation, control, register read). It absorbs variable memory latency and handles control-flow redirects by flushing buffered and in-flight instructions.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `FIFO_DEPTH`, 2, instruction buffer entries; power of two, ≥2

- `clk`  in  1  core clock
- `rst`  in  1  asynchronous, active-high reset
- `imem_req_valid`  out  1  fetch request valid
- `imem_req_ready`  in  1  memory accepts request
- `imem_req_addr`  out  32  word address, bits [1:0] always 0
- `imem_resp_valid`  in  1  response valid; no backpressure, in order, ≥1 cycle after acceptance
- `imem_resp_data`  in  32  instruction word
- `redirect_valid`  in  1  branch/jump taken, flush and restart
- `redirect_pc`  in  32  new fetch address
- `inst_valid`  out  1  `inst`/`inst_pc` valid
- `inst_ready`  in  1  decode consumes instruction
- `inst`  out  32  instruction word to decode
- `inst_pc`  out  32  address of `inst`
- `fetch_fault`  out  1  misaligned redirect trapped (see Configuration)

## Operation
- Registers: `fetch_pc`, `outstanding` (0..FIFO_DEPTH), `drop_cnt` (0..FIFO_DEPTH), FIFO of {pc, word}, FSM state.
- Issue rule: `imem_req_valid` = state≠FAULT && !redirect_valid && (occupancy + outstanding < FIFO_DEPTH). On handshake: `fetch_pc += 4` (32-bit wrap 0xFFFF_FFFC→0), `outstanding++`.
- Response: `outstanding--`; if `drop_cnt`>0, discard and `drop_cnt--`; else push {pc, word}. Credit rule guarantees FIFO never overflows.
- Output: FIFO head drives `inst`/`inst_pc`; pop on `inst_valid && inst_ready`.
- FSM: RUN → FLUSH on redirect with responses still owed; FLUSH → RUN when `drop_cnt` reaches 0; RUN/FLUSH → FAULT on trapped redirect; FAULT exits only via reset.
- Redirect (any state but FAULT): FIFO cleared, `fetch_pc` ← `redirect_pc`, `drop_cnt` ← `outstanding` after that cycle's response accounting (a response arriving in the redirect cycle is discarded). New requests issue from next cycle, also during FLUSH.
- Simultaneous pop and redirect: pop ignored, FIFO cleared. Simultaneous push and pop: occupancy unchanged.
- Redirect during FLUSH: `drop_cnt` reloaded with current `outstanding`.

## Timing
- Reset values: `imem_req_valid`=0 while `rst` high, `imem_req_addr`=RESET_PC, `inst_valid`=0, `inst`=0, `inst_pc`=0, `fetch_fault`=0, state RUN, all counters 0.
- First request in first cycle after reset release.
- Response at cycle N → `inst_valid` at N+1 (registered FIFO, no bypass).
- Redirect at cycle R → request for `redirect_pc` at R+1; earliest `inst_valid` for it at R+3 with 1-cycle memory.
- Zero-wait memory and always-ready decode: sustained 1 instruction/cycle once full pipeline, requires FIFO_DEPTH≥2.
- Reset asserted mid-operation: all state cleared immediately; late memory responses after reset are memory's responsibility to suppress.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined: redirect with `redirect_pc[1:0]`≠0 flushes FIFO, enters FAULT, asserts `fetch_fault` next cycle and holds it; no further requests; in-flight responses discarded.
- Undefined: `redirect_pc[1:0]` ignored (treated as 00), FAULT state absent, `fetch_fault` tied 0.

## Structure
- `defines.v` (shared, already included by decode blocks): FSM state encodings `FETCH_RUN/FLUSH/FAULT`, `INST_NOP` 32'h0000_0013, `PC_STEP` 4.
- One sub-module: `fetch_fifo` (parameterised depth, push/pop/clear, occupancy out).

## Test plan
- Reset release, memory 1-cycle latency, decode always ready → requests 0x0,0x4,0x8 on consecutive cycles; `inst_valid` from cycle 2, `inst_pc` increments by 4 each cycle.
- Decode stalls (`inst_ready`=0) 5 cycles → at most 2 requests outstanding+buffered, no loss, order preserved on release.
- Redirect to 0x100 with 2 requests outstanding → both responses dropped, next `inst_pc`=0x100, no stale instruction seen.
- Redirect in same cycle as response and pop → response discarded, pop ignored, request 0x100 next cycle.
- `fetch_pc`=0xFFFF_FFFC → next request address 0x0.
- With `FETCH_MISALIGN_TRAP_EN`, redirect to 0x102 → `fetch_fault`=1 next cycle, `imem_req_valid`=0 and `inst_valid`=0 until reset; without macro, request to 0x100.
